// File: rtl/huffman_pkg.sv
// Shared definitions for the Huffman encoder back end.
// Holds the table geometry, the symbol encodings, the packer state type and a bit-count helper.
package huffman_pkg;

  localparam int NSYM = 6;
  localparam int CW   = 8;

  localparam logic [7:0] A1 = 8'd1;
  localparam logic [7:0] A2 = 8'd2;
  localparam logic [7:0] A3 = 8'd3;
  localparam logic [7:0] A4 = 8'd4;
  localparam logic [7:0] A5 = 8'd5;
  localparam logic [7:0] A6 = 8'd6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } pk_state_e;

  // Number of set bits in a byte; masks are contiguous, so this is the code length.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/huffman_code_table.sv
// Six-entry code table: captures masked codes and their lengths on load,
// and looks up code/length for the current symbol combinationally.
module huffman_code_table
  import huffman_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_i,
  input  logic [NSYM-1:0][CW-1:0]  hc_i,
  input  logic [NSYM-1:0][CW-1:0]  m_i,
  input  logic [7:0]               sym_i,
  output logic [CW-1:0]            code_o,
  output logic [3:0]               len_o,
  output logic                     illegal_o
);

  logic [CW-1:0] code_q [NSYM];
  logic [3:0]    len_q  [NSYM];

  // Table registers; codes are stored pre-masked so bits above len are always zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NSYM; i++) begin
        code_q[i] <= '0;
        len_q[i]  <= '0;
      end
    end else if (load_i) begin
      for (int i = 0; i < NSYM; i++) begin
        code_q[i] <= hc_i[i] & m_i[i];
        len_q[i]  <= popcount8(m_i[i]);
      end
    end
  end

  // Symbol lookup; anything outside A1..A6 is flagged and yields an empty code.
  always_comb begin
    code_o    = '0;
    len_o     = '0;
    illegal_o = 1'b1;
    for (int i = 0; i < NSYM; i++) begin
      if (sym_i == A1 + 8'(i)) begin
        code_o    = code_q[i];
        len_o     = len_q[i];
        illegal_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/huffman_packer.sv
// Huffman packer: maps symbols to variable-length codes, packs them MSB-first
// into bytes over a valid/ready output, and pads the tail byte on flush.
module huffman_packer
  import huffman_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          code_valid,
  input  logic [CW-1:0] HC1,
  input  logic [CW-1:0] HC2,
  input  logic [CW-1:0] HC3,
  input  logic [CW-1:0] HC4,
  input  logic [CW-1:0] HC5,
  input  logic [CW-1:0] HC6,
  input  logic [CW-1:0] M1,
  input  logic [CW-1:0] M2,
  input  logic [CW-1:0] M3,
  input  logic [CW-1:0] M4,
  input  logic [CW-1:0] M5,
  input  logic [CW-1:0] M6,
  input  logic          sym_valid,
  input  logic [7:0]    sym_data,
  output logic          sym_ready,
  input  logic          flush,
  output logic          out_valid,
  output logic [7:0]    out_data,
  input  logic          out_ready,
  output logic          flush_done,
  output logic          sym_err,
  output logic [15:0]   total_bits
);

  pk_state_e     state_q;
  logic [15:0]   acc_q, acc_sh, acc_d;
  logic [4:0]    fill_q, fill_sh, fill_d, fill_pad;
  logic [15:0]   total_q;
  logic          flush_done_q, sym_err_q;
  logic          load, pop, accept, add;
  logic [CW-1:0] code;
  logic [3:0]    len;
  logic          illegal;
  logic [16:0]   total_sum;

  assign load = code_valid && (state_q != FLUSH);

  huffman_code_table u_table (
    .clk       (clk),
    .reset     (reset),
    .load_i    (load),
    .hc_i      ({HC6, HC5, HC4, HC3, HC2, HC1}),
    .m_i       ({M6, M5, M4, M3, M2, M1}),
    .sym_i     (sym_data),
    .code_o    (code),
    .len_o     (len),
    .illegal_o (illegal)
  );

  assign sym_ready  = (state_q == RUN) && (fill_q <= 5'd8);
  assign out_valid  = (fill_q >= 5'd8);
  assign out_data   = acc_q[15:8];
  assign flush_done = flush_done_q;
  assign sym_err    = sym_err_q;
  assign total_bits = total_q;

  // Next accumulator: drain the top byte first, then place the new code below the remaining bits.
  always_comb begin
    pop     = out_valid && out_ready;
    accept  = sym_valid && sym_ready;
    add     = accept && !illegal && (len != 4'd0);
    acc_sh  = pop ? {acc_q[7:0], 8'h00} : acc_q;
    fill_sh = pop ? (fill_q - 5'd8) : fill_q;
    acc_d   = acc_sh;
    fill_d  = fill_sh;
    if (add) begin
      acc_d  = acc_sh | ({8'h00, code} << (5'd16 - fill_sh - {1'b0, len}));
      fill_d = fill_sh + {1'b0, len};
    end
    // A partial byte is rounded up to a full one; the low bits are already zero.
    fill_pad  = ((fill_d != 5'd0) && (fill_d < 5'd8)) ? 5'd8 : fill_d;
    total_sum = {1'b0, total_q} + 17'(len);
  end

  // Control FSM, accumulator, bit counter and status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      fill_q       <= '0;
      total_q      <= '0;
      flush_done_q <= 1'b0;
      sym_err_q    <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      sym_err_q    <= accept && illegal;
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      if (add) begin
        total_q <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
      end
      case (state_q)
        IDLE: begin
          if (code_valid) begin
            state_q <= RUN;
          end else if (flush) begin
            flush_done_q <= 1'b1;
          end
        end
        RUN: begin
          if (flush) begin
            if (fill_d == 5'd0) begin
              flush_done_q <= 1'b1;
            end else begin
              fill_q  <= fill_pad;
              state_q <= FLUSH;
            end
          end
        end
        FLUSH: begin
          fill_q <= fill_pad;
          if (fill_pad == 5'd0) begin
            flush_done_q <= 1'b1;
            state_q      <= RUN;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (load) begin
        total_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_huffman_packer.sv
// Bench for huffman_packer: directed scenarios plus randomized traffic, all checked
// against a bit-queue reference model of the packing rules.
module tb_huffman_packer;
  import huffman_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        code_valid;
  logic [7:0]  hc_t [6];
  logic [7:0]  m_t  [6];
  logic        sym_valid;
  logic [7:0]  sym_data;
  logic        sym_ready;
  logic        flush;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        flush_done;
  logic        sym_err;
  logic [15:0] total_bits;

  huffman_packer dut (
    .clk(clk), .reset(reset), .code_valid(code_valid),
    .HC1(hc_t[0]), .HC2(hc_t[1]), .HC3(hc_t[2]), .HC4(hc_t[3]), .HC5(hc_t[4]), .HC6(hc_t[5]),
    .M1(m_t[0]), .M2(m_t[1]), .M3(m_t[2]), .M4(m_t[3]), .M5(m_t[4]), .M6(m_t[5]),
    .sym_valid(sym_valid), .sym_data(sym_data), .sym_ready(sym_ready),
    .flush(flush), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .flush_done(flush_done), .sym_err(sym_err), .total_bits(total_bits)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model state
  bit          bq[$];
  int unsigned tot;
  int          mode;
  bit          err_exp, done_exp;
  logic [7:0]  mhc [1:6];
  int          mlen [1:6];

  // Observation state
  logic [7:0]  got[$];
  bit          saw_done, last_acc;
  int          err_cnt, stall_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_byte();
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = bq[i];
    return b;
  endfunction

  task automatic model_reset();
    bq.delete();
    tot = 0; mode = 0; err_exp = 0; done_exp = 0;
    for (int s = 1; s <= 6; s++) begin mhc[s] = '0; mlen[s] = 0; end
  endtask

  task automatic step();
    bit acc_m, pop_m;
    int s;
    @(negedge clk);
    chk("sym_ready", {31'd0, sym_ready}, {31'd0, (mode == 1) && (bq.size() <= 8)});
    chk("out_valid", {31'd0, out_valid}, {31'd0, bq.size() >= 8});
    if (bq.size() >= 8) chk("out_data", {24'd0, out_data}, {24'd0, exp_byte()});
    chk("sym_err", {31'd0, sym_err}, {31'd0, err_exp});
    chk("flush_done", {31'd0, flush_done}, {31'd0, done_exp});
    chk("total_bits", {16'd0, total_bits}, tot);
    if (flush_done) saw_done = 1;
    if (sym_err) err_cnt++;
    if (sym_valid && !sym_ready) stall_cnt++;
    if (out_valid && out_ready) got.push_back(out_data);
    // model update for this cycle's inputs
    acc_m = sym_valid && (mode == 1) && (bq.size() <= 8);
    pop_m = (bq.size() >= 8) && out_ready;
    last_acc = acc_m;
    done_exp = 0; err_exp = 0;
    if (pop_m) repeat (8) void'(bq.pop_front());
    if (acc_m) begin
      if (sym_data >= 8'd1 && sym_data <= 8'd6) begin
        s = int'(sym_data);
        for (int b = mlen[s] - 1; b >= 0; b--) bq.push_back(mhc[s][b]);
        tot = (tot + mlen[s] > 65535) ? 65535 : tot + mlen[s];
      end else begin
        err_exp = 1;
      end
    end
    if (code_valid && mode != 2) begin
      for (int i = 0; i < 6; i++) begin
        mlen[i+1] = 0;
        for (int b = 0; b < 8; b++) mlen[i+1] += int'(m_t[i][b]);
        mhc[i+1] = hc_t[i];
      end
      tot = 0;
      if (mode == 0) mode = 1;
    end
    if (flush && mode != 2) begin
      if (mode == 0 || bq.size() == 0) done_exp = 1;
      else begin
        while (bq.size() % 8 != 0) bq.push_back(1'b0);
        mode = 2;
      end
    end else if (mode == 2 && bq.size() == 0) begin
      done_exp = 1;
      mode = 1;
    end
    @(posedge clk);
    #1;
    code_valid = 0;
    flush = 0;
  endtask

  task automatic load_std();
    hc_t = '{8'h00, 8'h02, 8'h06, 8'h0E, 8'h1E, 8'h1F};
    m_t  = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h1F};
    code_valid = 1;
    step();
  endtask

  task automatic send_sym(input logic [7:0] s);
    int n;
    sym_valid = 1; sym_data = s; n = 0;
    last_acc = 0;
    while (!last_acc && n < 50) begin step(); n++; end
    if (!last_acc) chk("sym_accept_timeout", 0, 1);
    sym_valid = 0;
  endtask

  task automatic do_flush();
    int n;
    saw_done = 0;
    flush = 1;
    step();
    n = 0;
    while (!saw_done && n < 60) begin step(); n++; end
    chk("flush_done_seen", {31'd0, saw_done}, 1);
  endtask

  initial begin
    reset = 1; code_valid = 0; sym_valid = 0; sym_data = 0; flush = 0; out_ready = 1;
    hc_t = '{default: 8'h00}; m_t = '{default: 8'h00};
    model_reset();
    #3;
    chk("rst_sym_ready", {31'd0, sym_ready}, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_data", {24'd0, out_data}, 0);
    chk("rst_total", {16'd0, total_bits}, 0);
    @(posedge clk); #1;
    reset = 0;

    // flush in IDLE: done the next cycle
    saw_done = 0; flush = 1; step(); step();
    chk("idle_flush_done", {31'd0, saw_done}, 1);

    // Scenario 1
    load_std(); got.delete();
    send_sym(8'd1); send_sym(8'd2); send_sym(8'd3);
    do_flush();
    chk("s1_nbytes", got.size(), 1);
    chk("s1_byte", {24'd0, got[0]}, 32'h58);
    chk("s1_total", {16'd0, total_bits}, 6);

    // Scenario 2
    load_std(); got.delete();
    send_sym(8'd6); send_sym(8'd6);
    do_flush();
    chk("s2_nbytes", got.size(), 2);
    chk("s2_byte0", {24'd0, got[0]}, 32'hFF);
    chk("s2_byte1", {24'd0, got[1]}, 32'hC0);
    chk("s2_total", {16'd0, total_bits}, 10);

    // Scenario 3: back-pressure holds the byte and stalls symbols
    load_std(); got.delete(); stall_cnt = 0;
    out_ready = 0; sym_valid = 1; sym_data = 8'd4;
    repeat (8) step();
    chk("s3_held", {24'd0, out_data}, 32'hEE);
    chk("s3_stall", {31'd0, stall_cnt > 0}, 1);
    out_ready = 1;
    repeat (6) step();
    sym_valid = 0;
    do_flush();
    chk("s3_first", {24'd0, got[0]}, 32'hEE);

    // Scenario 4: illegal symbol
    load_std(); got.delete(); err_cnt = 0;
    send_sym(8'd1); send_sym(8'h07); send_sym(8'd1);
    do_flush();
    chk("s4_err_cnt", err_cnt, 1);
    chk("s4_byte", {24'd0, got[0]}, 32'h00);
    chk("s4_total", {16'd0, total_bits}, 2);

    // Scenario 5: sixteen symbol 5s
    load_std(); got.delete();
    for (int k = 0; k < 16; k++) send_sym(8'd5);
    do_flush();
    chk("s5_nbytes", got.size(), 10);
    chk("s5_b0", {24'd0, got[0]}, 32'hF7);
    chk("s5_b1", {24'd0, got[1]}, 32'hBD);
    chk("s5_b2", {24'd0, got[2]}, 32'hEF);
    chk("s5_b3", {24'd0, got[3]}, 32'h7B);
    chk("s5_b4", {24'd0, got[4]}, 32'hDE);
    chk("s5_b9", {24'd0, got[9]}, 32'hDE);

    // Random traffic with random tables
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 6; i++) begin
        int l;
        l = int'($urandom_range(0, 8));
        m_t[i]  = 8'((16'h1 << l) - 16'h1);
        hc_t[i] = 8'($urandom);
      end
      code_valid = 1; sym_valid = 0; step();
      for (int c = 0; c < 300; c++) begin
        sym_valid = ($urandom_range(0, 3) != 0);
        sym_data  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(1, 6));
        out_ready = ($urandom_range(0, 9) < 7);
        flush     = (mode == 1) && ($urandom_range(0, 29) == 0);
        step();
      end
      sym_valid = 0; out_ready = 1;
      do_flush();
    end

    // Scenario 6: reset mid-FLUSH
    load_std();
    out_ready = 0;
    send_sym(8'd6); send_sym(8'd6);
    flush = 1; step(); step();
    #2 reset = 1;
    #1;
    chk("s6_sym_ready", {31'd0, sym_ready}, 0);
    chk("s6_out_valid", {31'd0, out_valid}, 0);
    chk("s6_out_data", {24'd0, out_data}, 0);
    chk("s6_flush_done", {31'd0, flush_done}, 0);
    chk("s6_sym_err", {31'd0, sym_err}, 0);
    chk("s6_total", {16'd0, total_bits}, 0);
    model_reset();
    @(posedge clk); #1;
    reset = 0; out_ready = 1;
    sym_valid = 1; sym_data = 8'd2;
    repeat (4) step();
    sym_valid = 0;
    load_std(); got.delete();
    send_sym(8'd2);
    do_flush();
    chk("s6_after", {24'd0, got[0]}, 32'h80);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
